// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data RAM between the CPU and a debug port.
// Optional debug burst lock is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int CNT_W    = 16,
    parameter int LOCK_MAX = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q,
    output logic [CNT_W-1:0]  conflict_cnt
);

    // last_q = 1 when the debug port held the most recent grant
    logic             last_q, last_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_owner_q, rsp_owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_win;

`ifdef DMEM_ARB_LOCK_EN
    localparam int LCNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic {ARB, LOCKED} state_t;
    state_t            state_q, state_d;
    logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;

    assign lock_win = (state_q == LOCKED) && dbg_lock && dbg_req;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ARB: begin
                if (dbg_gnt && dbg_lock) begin
                    state_d    = (LOCK_MAX > 1) ? LOCKED : ARB;
                    lock_cnt_d = (LOCK_MAX > 1) ? LCNT_W'(1) : '0;
                end
            end
            LOCKED: begin
                if (!dbg_lock) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else if (dbg_gnt) begin
                    // Burst budget spent: drop back so the cpu takes the next conflict
                    if (32'(lock_cnt_q) + 1 >= LOCK_MAX) begin
                        state_d    = ARB;
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ARB;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = dbg_lock;
    assign lock_win    = 1'b0;
`endif

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (lock_win) begin
            dbg_gnt = 1'b1;
        end else if (cpu_req && dbg_req) begin
            cpu_gnt = last_q;
            dbg_gnt = ~last_q;
        end else begin
            cpu_gnt = cpu_req;
            dbg_gnt = dbg_req;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign ram_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
    assign ram_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    assign ram_wen   = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);

    always_comb begin
        last_d      = last_q;
        rsp_valid_d = (cpu_gnt | dbg_gnt) & ~ram_wen;
        rsp_owner_d = dbg_gnt;
        cnt_d       = cnt_q;
        if (dbg_gnt) begin
            last_d = 1'b1;
        end else if (cpu_gnt) begin
            last_d = 1'b0;
        end
        if (cpu_req && dbg_req && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cpu_rvalid   = rsp_valid_q & ~rsp_owner_q;
    assign dbg_rvalid   = rsp_valid_q &  rsp_owner_q;
    assign cpu_rdata    = ram_q;
    assign dbg_rdata    = ram_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with an attached RAM and a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 16;
    localparam int LOCK_MAX = 3;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clock;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic              cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, ram_wen;
    logic [DATA_W-1:0] cpu_rdata, dbg_rdata, ram_wdata, ram_q;
    logic [ADDR_W-1:0] ram_addr;
    logic [CNT_W-1:0]  conflict_cnt;

    int vectors = 0;
    int errors  = 0;

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_q(ram_q),
        .conflict_cnt(conflict_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read, write-first RAM
    logic [DATA_W-1:0] ram [1 << ADDR_W];
    always @(posedge clock) begin
        if (ram_wen) begin
            ram[ram_addr] <= ram_wdata;
            ram_q         <= ram_wdata;
        end else begin
            ram_q <= ram[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    bit                m_last_dbg;
    int                m_cnt;
    bit                m_pv, m_pown;
    logic [DATA_W-1:0] m_pdata;
    logic [DATA_W-1:0] m_mem [1 << ADDR_W];
    bit                m_locked;
    int                m_lcnt;

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) m_mem[i] = '0;
    end

    // Returns {cpu wins, dbg wins} for the current requests
    function automatic logic [1:0] model_grant();
        bit locked_dbg = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
        locked_dbg = m_locked && dbg_lock && dbg_req;
`endif
        if (locked_dbg) return 2'b01;
        if (cpu_req && dbg_req) return m_last_dbg ? 2'b10 : 2'b01;
        return {cpu_req, dbg_req};
    endfunction

    logic [1:0]        mg;
    bit                m_own, m_we;
    logic [ADDR_W-1:0] m_a;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_last_dbg = 1'b1;
            m_cnt      = 0;
            m_pv       = 1'b0;
            m_locked   = 1'b0;
            m_lcnt     = 0;
        end else begin
            mg = model_grant();
            if (cpu_req && dbg_req && m_cnt < CNT_MAX) m_cnt++;
            m_pv = 1'b0;
            if (mg != 2'b00) begin
                m_own = mg[0];
                m_we  = m_own ? dbg_we : cpu_we;
                m_a   = m_own ? dbg_addr : cpu_addr;
                if (m_we) begin
                    m_mem[m_a] = m_own ? dbg_wdata : cpu_wdata;
                end else begin
                    m_pv    = 1'b1;
                    m_pown  = m_own;
                    m_pdata = m_mem[m_a];
                end
                m_last_dbg = m_own;
            end
`ifdef DMEM_ARB_LOCK_EN
            if (!dbg_lock) begin
                m_locked = 1'b0;
                m_lcnt   = 0;
            end else if (mg[0]) begin
                m_lcnt   = m_locked ? m_lcnt + 1 : 1;
                m_locked = 1'b1;
                if (m_lcnt >= LOCK_MAX) begin
                    m_locked = 1'b0;
                    m_lcnt   = 0;
                end
            end
`endif
        end
    end

    logic [1:0] eg;
    always @(negedge clock) begin
        eg = model_grant();
        check("cpu_gnt", 32'(cpu_gnt), 32'(eg[1]));
        check("dbg_gnt", 32'(dbg_gnt), 32'(eg[0]));
        check("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~eg[1]));
        check("ram_wen", 32'(ram_wen), 32'((eg[1] & cpu_we) | (eg[0] & dbg_we)));
        check("ram_addr", 32'(ram_addr), 32'(eg[0] ? dbg_addr : cpu_addr));
        if (eg != 2'b00) check("ram_wdata", ram_wdata, eg[0] ? dbg_wdata : cpu_wdata);
        check("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pv & ~m_pown));
        check("dbg_rvalid", 32'(dbg_rvalid), 32'(m_pv & m_pown));
        if (cpu_rvalid) check("cpu_rdata", cpu_rdata, m_pdata);
        if (dbg_rvalid) check("dbg_rdata", dbg_rdata, m_pdata);
        check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
        #1;
    endtask

    task automatic drive(input bit creq, input bit cwe, input logic [ADDR_W-1:0] ca,
                         input logic [DATA_W-1:0] cd, input bit dreq, input bit dwe,
                         input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] dd);
        cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dreq; dbg_we = dwe; dbg_addr = da; dbg_wdata = dd;
    endtask

    logic [7:0] lock_pat;

    initial begin
        cyc(); cyc(); cyc();
        at_neg();
        check("reset_cnt", 32'(conflict_cnt), 32'd0);
        check("reset_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        cyc();
        reset = 1'b0;

        // cpu write then read of 0x010
        drive(1, 1, 12'h010, 32'h0000_0055, 0, 0, '0, '0);
        at_neg();
        check("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("wr_cpu_stall", 32'(cpu_stall), 32'd0);
        cyc();
        drive(1, 0, 12'h010, '0, 0, 0, '0, '0);
        at_neg();
        check("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        cyc();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        at_neg();
        check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("rd_cpu_rdata", cpu_rdata, 32'h0000_0055);
        check("rd_dbg_rvalid", 32'(dbg_rvalid), 32'd0);

        // dbg preload of 0x020 leaves last=dbg, so the cpu takes the first conflict
        cyc();
        drive(0, 0, '0, '0, 1, 1, 12'h020, 32'hA5A5_A5A5);
        at_neg();
        check("pre_dbg_gnt", 32'(dbg_gnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            drive(1, 0, 12'h010, '0, 1, 0, 12'h020, '0);
            at_neg();
            check("alt_cpu_gnt", 32'(cpu_gnt), 32'(i % 2 == 0));
            check("alt_cpu_stall", 32'(cpu_stall), 32'(i % 2 == 1));
            if (i > 0) check("alt_cpu_rvalid", 32'(cpu_rvalid), 32'(i % 2 == 1));
        end
        cyc();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        at_neg();
        check("alt_cnt", 32'(conflict_cnt), 32'd4);
        check("alt_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        check("alt_dbg_rdata", dbg_rdata, 32'hA5A5_A5A5);

        // cpu wins a conflict, then loses the next to a dbg write it reads back
        cyc();
        drive(1, 0, 12'h010, '0, 1, 0, 12'h020, '0);
        at_neg();
        check("raw_pre_cpu_gnt", 32'(cpu_gnt), 32'd1);
        cyc();
        drive(1, 0, 12'h0FF, '0, 1, 1, 12'h0FF, 32'h1234_5678);
        at_neg();
        check("raw_dbg_gnt", 32'(dbg_gnt), 32'd1);
        check("raw_cpu_stall", 32'(cpu_stall), 32'd1);
        cyc();
        drive(1, 0, 12'h0FF, '0, 0, 0, '0, '0);
        at_neg();
        check("raw_cpu_gnt", 32'(cpu_gnt), 32'd1);
        cyc();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        at_neg();
        check("raw_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("raw_cpu_rdata", cpu_rdata, 32'h1234_5678);

        // reset lands while a cpu read response is due
        cyc();
        drive(1, 0, 12'h010, '0, 0, 0, '0, '0);
        cyc();
        reset = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        at_neg();
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check("rst_cnt", 32'(conflict_cnt), 32'd0);
        cyc(); cyc();
        reset = 1'b0;
        at_neg();
        check("post_rst_rvalid", 32'(cpu_rvalid), 32'd0);
        cyc();
        drive(1, 0, 12'h010, '0, 1, 0, 12'h020, '0);
        at_neg();
        check("post_rst_cpu_first", 32'(cpu_gnt), 32'd1);

        // debug lock burst (last=cpu here, so dbg starts)
`ifdef DMEM_ARB_LOCK_EN
        lock_pat = 8'b0111_0111;
`else
        lock_pat = 8'b0101_0101;
`endif
        for (int i = 0; i < 8; i++) begin
            cyc();
            drive(1, 0, 12'h010, '0, 1, 0, 12'h020, '0);
            dbg_lock = 1'b1;
            at_neg();
            check("lock_dbg_gnt", 32'(dbg_gnt), 32'(lock_pat[i]));
        end
        cyc();
        dbg_lock = 1'b0;

        // saturate the conflict counter
        drive(1, 0, 12'h010, '0, 1, 0, 12'h020, '0);
        for (int i = 0; i < 70000; i++) cyc();
        at_neg();
        check("sat_cnt", 32'(conflict_cnt), 32'd65535);
        cyc();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
